// File: rtl/mips_decode_stage.sv
// MIPS instruction-decode stage: field split, sign extension, GPR operand read,
// jump/branch next-PC resolution; all outputs registered. Optional macro ZERO_REG_EN.
module mips_decode_stage #(
  parameter int             DW       = 32,
  parameter logic [DW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   ir,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  input  logic [DW-1:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
  input  logic [DW-1:0] r16, r17, r18, r19, r20, r21, r22, r23,
  input  logic [DW-1:0] r24, r25, r26, r27, r28, r29, r30, r31,
  input  logic [DW-1:0] r32,
  output logic [DW-1:0] npc,
  output logic          pc_s,
  output logic [DW-1:0] sign_e,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [5:0]    opcode,
  output logic [4:0]    src,
  output logic [4:0]    target,
  output logic [4:0]    dest
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [DW-1:0] gpr [32];
  logic [DW-1:0] a_nxt, b_nxt, sign_nxt, seq, npc_nxt;
  logic          pc_s_nxt;
  logic          unused_inputs;

`ifdef ZERO_REG_EN
  assign gpr[0]        = '0;
  assign unused_inputs = ^{r0, r32};
`else
  assign gpr[0]        = r0;
  assign unused_inputs = ^r32;
`endif
  assign gpr[1]  = r1;  assign gpr[2]  = r2;  assign gpr[3]  = r3;
  assign gpr[4]  = r4;  assign gpr[5]  = r5;  assign gpr[6]  = r6;
  assign gpr[7]  = r7;  assign gpr[8]  = r8;  assign gpr[9]  = r9;
  assign gpr[10] = r10; assign gpr[11] = r11; assign gpr[12] = r12;
  assign gpr[13] = r13; assign gpr[14] = r14; assign gpr[15] = r15;
  assign gpr[16] = r16; assign gpr[17] = r17; assign gpr[18] = r18;
  assign gpr[19] = r19; assign gpr[20] = r20; assign gpr[21] = r21;
  assign gpr[22] = r22; assign gpr[23] = r23; assign gpr[24] = r24;
  assign gpr[25] = r25; assign gpr[26] = r26; assign gpr[27] = r27;
  assign gpr[28] = r28; assign gpr[29] = r29; assign gpr[30] = r30;
  assign gpr[31] = r31;

  assign a_nxt    = gpr[ir[25:21]];
  assign b_nxt    = gpr[ir[20:16]];
  assign sign_nxt = {{(DW-16){ir[15]}}, ir[15:0]};
  assign seq      = pc_in + DW'(4);

  // Branch compare uses the freshly muxed operands, not the registered ones.
  always_comb begin
    pc_s_nxt = 1'b0;
    npc_nxt  = seq;
    case (ir[31:26])
      OP_J: begin
        pc_s_nxt = 1'b1;
        npc_nxt  = {seq[DW-1:DW-4], ir[25:0], 2'b00};
      end
      OP_BEQ: begin
        if (a_nxt == b_nxt) begin
          pc_s_nxt = 1'b1;
          npc_nxt  = seq + (sign_nxt << 2);
        end
      end
      OP_BNE: begin
        if (a_nxt != b_nxt) begin
          pc_s_nxt = 1'b1;
          npc_nxt  = seq + (sign_nxt << 2);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      npc    <= RESET_PC;
      pc_s   <= 1'b0;
      sign_e <= '0;
      a      <= '0;
      b      <= '0;
      opcode <= '0;
      src    <= '0;
      target <= '0;
      dest   <= '0;
    end else begin
      npc    <= npc_nxt;
      pc_s   <= pc_s_nxt;
      sign_e <= sign_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      opcode <= ir[31:26];
      src    <= ir[25:21];
      target <= ir[20:16];
      dest   <= ir[15:11];
    end
  end

endmodule

// File: tb/tb_mips_decode_stage.sv
// Directed bench for mips_decode_stage with an expected-output queue.
// Define ZERO_REG_EN here too when the DUT is built with it.
module tb_mips_decode_stage;

  typedef struct packed {
    logic [31:0] npc;
    logic        pc_s;
    logic [31:0] sign_e;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  opcode;
    logic [4:0]  src;
    logic [4:0]  target;
    logic [4:0]  dest;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir, pc_in;
  logic [31:0] r [0:32];
  logic [31:0] npc, sign_e, a, b;
  logic        pc_s;
  logic [5:0]  opcode;
  logic [4:0]  src, target, dest;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  mips_decode_stage dut (
    .clk(clk), .reset(reset), .ir(ir), .pc_in(pc_in),
    .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),   .r4(r[4]),
    .r5(r[5]),   .r6(r[6]),   .r7(r[7]),   .r8(r[8]),   .r9(r[9]),
    .r10(r[10]), .r11(r[11]), .r12(r[12]), .r13(r[13]), .r14(r[14]),
    .r15(r[15]), .r16(r[16]), .r17(r[17]), .r18(r[18]), .r19(r[19]),
    .r20(r[20]), .r21(r[21]), .r22(r[22]), .r23(r[23]), .r24(r[24]),
    .r25(r[25]), .r26(r[26]), .r27(r[27]), .r28(r[28]), .r29(r[29]),
    .r30(r[30]), .r31(r[31]), .r32(r[32]),
    .npc(npc), .pc_s(pc_s), .sign_e(sign_e), .a(a), .b(b),
    .opcode(opcode), .src(src), .target(target), .dest(dest)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input out_t e);
    cmp({tag, ".npc"},    npc,           e.npc);
    cmp({tag, ".pc_s"},   32'(pc_s),     32'(e.pc_s));
    cmp({tag, ".sign_e"}, sign_e,        e.sign_e);
    cmp({tag, ".a"},      a,             e.a);
    cmp({tag, ".b"},      b,             e.b);
    cmp({tag, ".opcode"}, 32'(opcode),   32'(e.opcode));
    cmp({tag, ".src"},    32'(src),      32'(e.src));
    cmp({tag, ".target"}, 32'(target),   32'(e.target));
    cmp({tag, ".dest"},   32'(dest),     32'(e.dest));
  endtask

  // driver: present one instruction, queue its expectation, check after the edge
  task automatic apply(input string tag, input logic [31:0] i, input logic [31:0] pc,
                       input out_t e);
    out_t got;
    @(negedge clk);
    ir    = i;
    pc_in = pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      got = exp_q.pop_front();
      check_outputs(tag, got);
    end
  endtask

  function automatic out_t mk(input logic [31:0] n, input logic ps, input logic [31:0] se,
                              input logic [31:0] av, input logic [31:0] bv,
                              input logic [5:0] op, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d);
    out_t o;
    o.npc = n; o.pc_s = ps; o.sign_e = se; o.a = av; o.b = bv;
    o.opcode = op; o.src = s; o.target = t; o.dest = d;
    return o;
  endfunction

  initial begin
    out_t zero_o;
    logic [31:0] zr_a;
    logic        zr_taken;
    zero_o = mk(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 5'h0, 5'h0, 5'h0);
    for (int k = 0; k <= 32; k++) r[k] = $urandom_range(32'h7FFF_FFFF, 32'h1000);
    r[0] = 32'h0000_DEAD; r[1] = 32'h11; r[2] = 32'h5; r[3] = 32'h5;
    r[4] = 32'h44; r[10] = 32'hAA; r[31] = 32'h31;
    ir = 32'h0821_0800;
    pc_in = 32'h100;
    reset = 1'b0;

    // reset held low with the clock running
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_hold", zero_o);
    @(negedge clk);
    reset = 1'b1;

    apply("rtype", 32'h0421_0800, 32'h100,
          mk(32'h104, 1'b0, 32'h800, 32'h11, 32'h11, 6'd1, 5'd1, 5'd1, 5'd1));
    apply("jump", 32'h0821_0800, 32'h100,
          mk(32'h0084_2000, 1'b1, 32'h800, 32'h11, 32'h11, 6'd2, 5'd1, 5'd1, 5'd1));
    apply("beq_taken", 32'h1043_0002, 32'h100,
          mk(32'h10C, 1'b1, 32'h2, 32'h5, 32'h5, 6'd4, 5'd2, 5'd3, 5'd0));
    r[3] = 32'h6;
    apply("beq_not", 32'h1043_0002, 32'h100,
          mk(32'h104, 1'b0, 32'h2, 32'h5, 32'h6, 6'd4, 5'd2, 5'd3, 5'd0));
    apply("bne_taken", 32'h1443_0002, 32'h100,
          mk(32'h10C, 1'b1, 32'h2, 32'h5, 32'h6, 6'd5, 5'd2, 5'd3, 5'd0));
    r[3] = 32'h5;
    apply("bne_not", 32'h1443_0002, 32'h100,
          mk(32'h104, 1'b0, 32'h2, 32'h5, 32'h5, 6'd5, 5'd2, 5'd3, 5'd0));
    apply("beq_neg", 32'h1043_FFFF, 32'h100,
          mk(32'h100, 1'b1, 32'hFFFF_FFFF, 32'h5, 32'h5, 6'd4, 5'd2, 5'd3, 5'd31));
    apply("seq_wrap", 32'h0421_0800, 32'hFFFF_FFFC,
          mk(32'h0, 1'b0, 32'h800, 32'h11, 32'h11, 6'd1, 5'd1, 5'd1, 5'd1));
    apply("jump_hi", 32'h0BFF_FFFF, 32'hF000_0000,
          mk(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 32'h31, 32'h31, 6'd2, 5'd31, 5'd31, 5'd31));
    apply("undef_op", 32'hFC8A_5678, 32'h200,
          mk(32'h204, 1'b0, 32'h5678, 32'h44, 32'hAA, 6'h3F, 5'd4, 5'd10, 5'd10));

    // index 0 read and compared against r1=0 through BEQ
    r[1] = 32'h0;
`ifdef ZERO_REG_EN
    zr_a = 32'h0;     zr_taken = 1'b1;
`else
    zr_a = 32'hDEAD;  zr_taken = 1'b0;
`endif
    apply("zero_reg", 32'h1001_0004, 32'h100,
          mk(zr_taken ? 32'h114 : 32'h104, zr_taken, 32'h4, zr_a, 32'h0,
             6'd4, 5'd0, 5'd1, 5'd0));

    // asynchronous reset mid-run clears outputs before the next edge
    @(negedge clk);
    ir = 32'h0821_0800; pc_in = 32'h100;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("reset_async", zero_o);
    @(negedge clk);
    reset = 1'b1;
    apply("post_reset", 32'h0421_0800, 32'h100,
          mk(32'h104, 1'b0, 32'h800, 32'h0, 32'h0, 6'd1, 5'd1, 5'd1, 5'd1));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
